chip_order_sequencer: RTL and testbench

//  Upstream stage of the chip dispenser. Accepts one order of N red, M green and K blue

---
 rtl/chip_pkg.sv | 27 ++
 rtl/seq_cycle_timer.sv | 34 +++
 rtl/chip_order_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_chip_order_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_pkg.sv
// Shared colour codes and sequencer state encoding for the chip dispenser path.
package chip_pkg;

  localparam logic [1:0] COL_RED   = 2'b00;
  localparam logic [1:0] COL_GREEN = 2'b01;
  localparam logic [1:0] COL_BLUE  = 2'b10;
  localparam logic [1:0] COL_NONE  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ARM,
    ISSUE,
    WAIT
  } seq_state_e;

  // Colour priority is fixed: red first, then green, then blue.
  function automatic logic [1:0] first_colour(input logic red_nz,
                                              input logic green_nz,
                                              input logic blue_nz);
    if (red_nz)   return COL_RED;
    if (green_nz) return COL_GREEN;
    if (blue_nz)  return COL_BLUE;
    return COL_NONE;
  endfunction

endpackage

// File: rtl/seq_cycle_timer.sv
// Saturating cycle counter with synchronous clear; flags when the count reaches a limit.
module seq_cycle_timer #(
  parameter int unsigned TIMER_W = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic [TIMER_W-1:0] limit_i,
  output logic               reached_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign reached_o = (count_q >= limit_i);

endmodule

// File: rtl/chip_order_sequencer.sv
// Turns one red/green/blue chip order into single-chip requests for the dispenser,
// re-arming it between chips and reporting done, timeout and abort status.
module chip_order_sequencer
  import chip_pkg::*;
#(
  parameter int unsigned COUNT_W        = 4,
  parameter int unsigned ARM_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned TIMER_W        = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               order_valid_i,
  output logic               order_ready_o,
  input  logic [COUNT_W-1:0] order_red_i,
  input  logic [COUNT_W-1:0] order_green_i,
  input  logic [COUNT_W-1:0] order_blue_i,
  input  logic               abort_i,
  input  logic               complete_i,
  output logic [1:0]         dispense_o,
  output logic               start_o,
  output logic               busy_o,
  output logic               order_done_o,
  output logic               fault_o,
  output logic [COUNT_W+1:0] chips_left_o
);

  localparam int unsigned          LEFT_W    = COUNT_W + 2;
  localparam logic [TIMER_W-1:0]   ARM_LIMIT = TIMER_W'(ARM_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   TO_LIMIT  = TIMER_W'(TIMEOUT_CYCLES - 1);

  seq_state_e          state_q, state_d;
  logic [COUNT_W-1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [1:0]          sel_q, sel_d;
  logic [LEFT_W-1:0]   chips_q, chips_d;
  logic                fault_q, fault_d;
  logic                complete_q;
  logic [1:0]          dispense_q, dispense_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;

  logic                accept, done_edge, counts_zero, timer_reached;
  logic                wait_done, timed_out;

  assign accept      = (state_q == IDLE) && order_valid_i && ready_q;
  assign done_edge   = complete_i && !complete_q;
  assign counts_zero = (red_q == '0) && (green_q == '0) && (blue_q == '0);
  assign wait_done   = (state_q == WAIT) && !abort_i && done_edge;
  assign timed_out   = (state_q == WAIT) && !abort_i && !done_edge && timer_reached;

  seq_cycle_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (!((state_q == ARM) || (state_q == WAIT))),
    .enable_i ((state_q == ARM) || (state_q == WAIT)),
    .limit_i  ((state_q == ARM) ? ARM_LIMIT : TO_LIMIT),
    .reached_o(timer_reached)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q != IDLE) && abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = SELECT;
        SELECT:  state_d = counts_zero ? IDLE : ARM;
        ARM:     if (timer_reached) state_d = ISSUE;
        ISSUE:   state_d = WAIT;
        WAIT: begin
          if (done_edge)          state_d = SELECT;
          else if (timer_reached) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Dispense holds its colour through SELECT so the NONE gap is exactly the ARM hold.
  always_comb begin
    dispense_d = dispense_q;
    start_d    = start_q;
    case (state_d)
      IDLE: begin
        dispense_d = COL_NONE;
        start_d    = 1'b0;
      end
      SELECT:  start_d = 1'b0;
      ARM: begin
        dispense_d = COL_NONE;
        start_d    = 1'b0;
      end
      ISSUE, WAIT: begin
        dispense_d = sel_q;
        start_d    = 1'b1;
      end
      default: begin
        dispense_d = COL_NONE;
        start_d    = 1'b0;
      end
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_q == SELECT) && !abort_i && counts_zero;
  end

  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    sel_d   = sel_q;
    chips_d = chips_q;
    fault_d = fault_q;
    if (accept) begin
      red_d   = order_red_i;
      green_d = order_green_i;
      blue_d  = order_blue_i;
      chips_d = LEFT_W'(order_red_i) + LEFT_W'(order_green_i) + LEFT_W'(order_blue_i);
      fault_d = 1'b0;
    end
    if (state_q == SELECT) begin
      sel_d = first_colour(red_q != '0, green_q != '0, blue_q != '0);
    end
    if (wait_done) begin
      case (sel_q)
        COL_RED:   if (red_q   != '0) red_d   = red_q   - COUNT_W'(1);
        COL_GREEN: if (green_q != '0) green_d = green_q - COUNT_W'(1);
        COL_BLUE:  if (blue_q  != '0) blue_d  = blue_q  - COUNT_W'(1);
        default:   ;
      endcase
      if (chips_q != '0) chips_d = chips_q - LEFT_W'(1);
    end
    if (timed_out) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      sel_q      <= COL_NONE;
      chips_q    <= '0;
      fault_q    <= 1'b0;
      complete_q <= 1'b0;
      dispense_q <= COL_NONE;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      sel_q      <= sel_d;
      chips_q    <= chips_d;
      fault_q    <= fault_d;
      complete_q <= complete_i;
      dispense_q <= dispense_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign order_ready_o = ready_q;
  assign dispense_o    = dispense_q;
  assign start_o       = start_q;
  assign busy_o        = busy_q;
  assign order_done_o  = done_q;
  assign fault_o       = fault_q;
  assign chips_left_o  = chips_q;

endmodule

// File: tb/tb_chip_order_sequencer.sv
// Directed bench for chip_order_sequencer with a simple dispenser model
// (complete rises 50 cycles after start, drops when start drops).
module tb_chip_order_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        order_valid_i;
  logic [3:0]  order_red_i, order_green_i, order_blue_i;
  logic        abort_i;
  logic        complete_i;
  logic        order_ready_o, start_o, busy_o, order_done_o, fault_o;
  logic [1:0]  dispense_o;
  logic [5:0]  chips_left_o;

  logic        modelOn, modelComplete, manualComplete;
  int          modelCnt;
  int          total = 0;
  int          bad = 0;
  int          n;

  logic [1:0]  dispLog[$];
  int          gapLog[$];
  int          chipsLog[$];
  int          donePulses, startCycles, doneAt;
  bit          runTimedOut;
  logic        firstFault;

  logic [1:0]  expDisp1[6] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10};
  int          expChips[4] = '{3, 2, 1, 0};

  assign complete_i = (modelOn & modelComplete) | manualComplete;

  always #5 clk = ~clk;

  chip_order_sequencer #(
    .COUNT_W       (4),
    .ARM_CYCLES    (2),
    .TIMEOUT_CYCLES(1000),
    .TIMER_W       (27)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .order_valid_i(order_valid_i),
    .order_ready_o(order_ready_o),
    .order_red_i  (order_red_i),
    .order_green_i(order_green_i),
    .order_blue_i (order_blue_i),
    .abort_i      (abort_i),
    .complete_i   (complete_i),
    .dispense_o   (dispense_o),
    .start_o      (start_o),
    .busy_o       (busy_o),
    .order_done_o (order_done_o),
    .fault_o      (fault_o),
    .chips_left_o (chips_left_o)
  );

  // Dispenser model, updated on the falling edge away from DUT sampling.
  initial begin
    modelComplete = 1'b0;
    modelCnt = 0;
    forever begin
      @(negedge clk);
      if (start_o) begin
        modelCnt++;
        modelComplete = (modelCnt >= 50);
      end else begin
        modelCnt = 0;
        modelComplete = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one order for a single cycle and record what happens until busy drops.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                               input int budget);
    logic [1:0] prev;
    int run;
    bit seenColour;
    bit finished;
    dispLog.delete();
    gapLog.delete();
    chipsLog.delete();
    donePulses = 0;
    startCycles = 0;
    doneAt = -1;
    runTimedOut = 0;
    run = 0;
    seenColour = 0;
    finished = 0;
    @(negedge clk);
    order_red_i = r;
    order_green_i = g;
    order_blue_i = b;
    order_valid_i = 1'b1;
    prev = dispense_o;
    dispLog.push_back(prev);
    for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        order_valid_i = 1'b0;
        firstFault = fault_o;
      end
      if (dispense_o != prev) begin
        dispLog.push_back(dispense_o);
        if (prev == 2'b11 && seenColour) gapLog.push_back(run);
        prev = dispense_o;
      end
      if (dispense_o == 2'b11) run++;
      else begin
        run = 0;
        seenColour = 1;
      end
      if (chipsLog.size() == 0 || chipsLog[$] != int'(chips_left_o))
        chipsLog.push_back(int'(chips_left_o));
      if (order_done_o) begin
        donePulses++;
        doneAt = cyc;
      end
      if (start_o) startCycles++;
      if (manualComplete && startCycles >= 10) begin
        checkOutput("held complete ignored", 32'(chips_left_o), int'(r) + int'(g) + int'(b));
        manualComplete = 1'b0;
      end
      if (!busy_o) finished = 1;
    end
    if (!finished) runTimedOut = 1;
    repeat (3) begin
      @(negedge clk);
      if (order_done_o) donePulses++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    order_valid_i = 1'b0;
    order_red_i = '0;
    order_green_i = '0;
    order_blue_i = '0;
    abort_i = 1'b0;
    modelOn = 1'b1;
    manualComplete = 1'b0;
    firstFault = 1'b0;
    #12;
    checkOutput("reset ready", 32'(order_ready_o), 1);
    checkOutput("reset dispense", 32'(dispense_o), 3);
    checkOutput("reset start", 32'(start_o), 0);
    checkOutput("reset busy", 32'(busy_o), 0);
    checkOutput("reset done", 32'(order_done_o), 0);
    checkOutput("reset fault", 32'(fault_o), 0);
    checkOutput("reset chips", 32'(chips_left_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] order r=2 g=0 b=1");
    applyStimulus(4'd2, 4'd0, 4'd1, 600);
    checkOutput("t1 finished", 32'(runTimedOut), 0);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t1 dispense[%0d]", i),
                  (i < dispLog.size()) ? 32'(dispLog[i]) : 32'hFF, 32'(expDisp1[i]));
    checkOutput("t1 chips steps", chipsLog.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t1 chips[%0d]", i),
                  (i < chipsLog.size()) ? chipsLog[i] : -1, expChips[i]);
    checkOutput("t1 done pulses", donePulses, 1);
    checkOutput("t1 fault", 32'(fault_o), 0);

    $display("[TB] zero-size order");
    applyStimulus(4'd0, 4'd0, 4'd0, 20);
    checkOutput("t2 done latency", doneAt, 2);
    checkOutput("t2 done pulses", donePulses, 1);
    checkOutput("t2 start cycles", startCycles, 0);
    checkOutput("t2 dispense changes", dispLog.size(), 1);

    // Valid held across the cycle IDLE is re-entered must yield only one order.
    @(negedge clk);
    order_valid_i = 1'b1;
    @(negedge clk);
    checkOutput("t2 ready while busy", 32'(order_ready_o), 0);
    @(negedge clk);
    order_valid_i = 1'b0;
    donePulses = 0;
    if (order_done_o) donePulses++;
    checkOutput("t2 ready back", 32'(order_ready_o), 1);
    repeat (5) begin
      @(negedge clk);
      if (order_done_o) donePulses++;
    end
    checkOutput("t2 single accept", donePulses, 1);

    $display("[TB] same-colour repeat g=3 with stale complete");
    manualComplete = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(4'd0, 4'd3, 4'd0, 800);
    checkOutput("t3 finished", 32'(runTimedOut), 0);
    checkOutput("t3 hold released", 32'(manualComplete), 0);
    checkOutput("t3 gap count", gapLog.size(), 2);
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("t3 gap[%0d]", i), (i < gapLog.size()) ? gapLog[i] : -1, 2);
    checkOutput("t3 first colour", (dispLog.size() > 1) ? 32'(dispLog[1]) : 32'hFF, 1);
    checkOutput("t3 chips steps", chipsLog.size(), 4);
    checkOutput("t3 chips end", (chipsLog.size() > 0) ? chipsLog[$] : -1, 0);
    checkOutput("t3 done pulses", donePulses, 1);

    $display("[TB] dispenser never completes");
    modelOn = 1'b0;
    applyStimulus(4'd1, 4'd0, 4'd0, 1300);
    checkOutput("t4 finished", 32'(runTimedOut), 0);
    checkOutput("t4 fault", 32'(fault_o), 1);
    checkOutput("t4 start cycles", startCycles, 1001);
    checkOutput("t4 start low", 32'(start_o), 0);
    checkOutput("t4 dispense none", 32'(dispense_o), 3);
    checkOutput("t4 done pulses", donePulses, 0);
    modelOn = 1'b1;
    applyStimulus(4'd0, 4'd1, 4'd0, 400);
    checkOutput("t4 fault cleared on accept", 32'(firstFault), 0);
    checkOutput("t4 next order done", donePulses, 1);
    checkOutput("t4 fault after next", 32'(fault_o), 0);

    $display("[TB] abort during chip 2 of r=4");
    modelOn = 1'b0;
    @(negedge clk);
    order_red_i = 4'd4;
    order_green_i = 4'd0;
    order_blue_i = 4'd0;
    order_valid_i = 1'b1;
    @(negedge clk);
    order_valid_i = 1'b0;
    n = 0;
    while (!start_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5 chip1 issued", 32'(start_o), 1);
    repeat (5) @(negedge clk);
    manualComplete = 1'b1;
    n = 0;
    while (start_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    manualComplete = 1'b0;
    checkOutput("t5 chip1 done", 32'(start_o), 0);
    checkOutput("t5 chips after chip1", 32'(chips_left_o), 3);
    n = 0;
    while (!start_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5 chip2 issued", 32'(start_o), 1);
    repeat (5) @(negedge clk);
    manualComplete = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    checkOutput("t5 abort start", 32'(start_o), 0);
    checkOutput("t5 abort dispense", 32'(dispense_o), 3);
    checkOutput("t5 abort busy", 32'(busy_o), 0);
    checkOutput("t5 abort chips", 32'(chips_left_o), 3);
    checkOutput("t5 abort done", 32'(order_done_o), 0);
    checkOutput("t5 abort fault", 32'(fault_o), 0);
    checkOutput("t5 abort ready", 32'(order_ready_o), 1);
    abort_i = 1'b0;
    manualComplete = 1'b0;
    donePulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (order_done_o) donePulses++;
    end
    checkOutput("t5 no done after abort", donePulses, 0);
    checkOutput("t5 chips hold", 32'(chips_left_o), 3);

    $display("[TB] async reset mid-wait");
    @(negedge clk);
    order_red_i = 4'd1;
    order_valid_i = 1'b1;
    @(negedge clk);
    order_valid_i = 1'b0;
    n = 0;
    while (!start_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6 issued", 32'(start_o), 1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 rst start", 32'(start_o), 0);
    checkOutput("t6 rst dispense", 32'(dispense_o), 3);
    checkOutput("t6 rst busy", 32'(busy_o), 0);
    checkOutput("t6 rst ready", 32'(order_ready_o), 1);
    checkOutput("t6 rst chips", 32'(chips_left_o), 0);
    checkOutput("t6 rst fault", 32'(fault_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    modelOn = 1'b1;
    applyStimulus(4'd1, 4'd0, 4'd0, 300);
    checkOutput("t6 finished", 32'(runTimedOut), 0);
    checkOutput("t6 done pulses", donePulses, 1);
    checkOutput("t6 chips end", 32'(chips_left_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
